led_ctrl: RTL

Parametrised switch-to-LED controller for the board I/O layer. It debounces N slide switches and drives N LEDs in one of four modes: direct, blink, chase, or PWM dim. Switches enter through a two-flop synchroniser and a per-bit debouncer. A shared prescaler tick paces blink and chase. All outputs are registered.

---
 rtl/led_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/led_ctrl.sv
// rtl/led_ctrl.sv - debounced switch-to-LED controller with direct, blink, chase and PWM modes
module led_ctrl #(
   parameter int N          = 8,
   parameter int DEB_CYCLES = 16,
   parameter int TICK_DIV   = 50_000_000,
   parameter int PWM_BITS   = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N-1:0]        sw,
   input  logic [1:0]          mode,
   input  logic [PWM_BITS-1:0] duty,
   output logic [N-1:0]        led,
   output logic [N-1:0]        sw_db,
   output logic                tick
);

   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      MODE_DIRECT = 2'b00,
      MODE_BLINK  = 2'b01,
      MODE_CHASE  = 2'b10,
      MODE_PWM    = 2'b11
   } mode_e;

   logic [N-1:0]          sync1_q, sync1_d;
   logic [N-1:0]          sync2_q, sync2_d;
   logic [N-1:0][CW-1:0]  cnt_q, cnt_d;
   logic [N-1:0]          sw_db_q, sw_db_d;
   logic [PW-1:0]         pre_q, pre_d;
   logic                  tick_q, tick_d;
   logic                  phase_q, phase_d;
   logic [N-1:0]          chase_q, chase_d;
   logic [N-1:0]          chase_rot;
   logic [PWM_BITS-1:0]   pwm_q, pwm_d;
   logic                  pwm_on;
   logic [N-1:0]          led_q, led_d;

   generate
      if (N == 1) begin : g_rot_single
         assign chase_rot = chase_q;
      end else begin : g_rot_multi
         assign chase_rot = {chase_q[N-2:0], chase_q[N-1]};
      end
   endgenerate

   assign pwm_on = (pwm_q < duty);

   always_comb begin
      sync1_d = sw;
      sync2_d = sync1_q;
      sw_db_d = sw_db_q;
      cnt_d   = '0;
      // A bit must disagree for DEB_CYCLES consecutive cycles before it is accepted
      for (int i = 0; i < N; i++) begin
         if (sync2_q[i] != sw_db_q[i]) begin
            if (cnt_q[i] == DEB_LAST) begin
               sw_db_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end

      pre_d   = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
      tick_d  = (pre_d == PRE_LAST);
      phase_d = phase_q ^ tick_q;
      chase_d = tick_q ? chase_rot : chase_q;
      pwm_d   = pwm_q + 1'b1;

      led_d = sw_db_q;
      case (mode_e'(mode))
         MODE_DIRECT: led_d = sw_db_q;
         MODE_BLINK:  led_d = phase_q ? sw_db_q : '0;
         MODE_CHASE:  led_d = chase_q & sw_db_q;
         MODE_PWM:    led_d = pwm_on ? sw_db_q : '0;
         default:     led_d = sw_db_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         cnt_q   <= '0;
         sw_db_q <= '0;
         pre_q   <= '0;
         tick_q  <= 1'b0;
         phase_q <= 1'b0;
         chase_q <= N'(1);
         pwm_q   <= '0;
         led_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         cnt_q   <= cnt_d;
         sw_db_q <= sw_db_d;
         pre_q   <= pre_d;
         tick_q  <= tick_d;
         phase_q <= phase_d;
         chase_q <= chase_d;
         pwm_q   <= pwm_d;
         led_q   <= led_d;
      end
   end

   assign led   = led_q;
   assign sw_db = sw_db_q;
   assign tick  = tick_q;

endmodule
